// File: rtl/alu_32bit.sv
// alu_32bit: registered 32-bit integer ALU producing a result plus parity/zero/sign/carry flags.
// Latency 1 cycle; accepts a new operation every cycle, no handshake and no backpressure.
module alu_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       opcode,
    output logic [WIDTH-1:0] alu_out,
    output logic             parity_flag,
    output logic             zero_flag,
    output logic             sign_flag,
    output logic             carry_flag
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_INC  = 4'd2,
        OP_DEC  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_NOT  = 4'd7,
        OP_SHL  = 4'd8,
        OP_SHR  = 4'd9,
        OP_SRA  = 4'd10,
        OP_ROL  = 4'd11,
        OP_ROR  = 4'd12,
        OP_SLT  = 4'd13,
        OP_SLTU = 4'd14,
        OP_PASS = 4'd15
    } op_t;

    logic [4:0]        shamt;
    logic [WIDTH:0]    add_ext;
    logic [WIDTH:0]    sub_ext;
    logic [WIDTH:0]    inc_ext;
    logic [WIDTH:0]    dec_ext;
    logic [WIDTH:0]    shl_ext;
    logic [WIDTH:0]    shr_ext;
    logic signed [WIDTH:0] sra_ext;
    logic [WIDTH-1:0]  res;
    logic              carry;

    assign shamt   = in2[4:0];
    assign add_ext = {1'b0, in1} + {1'b0, in2};
    assign sub_ext = {1'b0, in1} - {1'b0, in2};
    assign inc_ext = {1'b0, in1} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_ext = {1'b0, in1} - {{WIDTH{1'b0}}, 1'b1};

    // One guard bit beside the operand catches the last bit shifted out (stays 0 for amount 0).
    assign shl_ext = {1'b0, in1} << shamt;
    assign shr_ext = {in1, 1'b0} >> shamt;
    assign sra_ext = $signed({in1, 1'b0}) >>> shamt;

    always_comb begin
        res   = '0;
        carry = 1'b0;
        case (op_t'(opcode))
            OP_ADD: begin
                res   = add_ext[WIDTH-1:0];
                carry = add_ext[WIDTH];
            end
            OP_SUB: begin
                res   = sub_ext[WIDTH-1:0];
                carry = sub_ext[WIDTH];
            end
            OP_INC: begin
                res   = inc_ext[WIDTH-1:0];
                carry = inc_ext[WIDTH];
            end
            OP_DEC: begin
                res   = dec_ext[WIDTH-1:0];
                carry = dec_ext[WIDTH];
            end
            OP_AND:  res = in1 & in2;
            OP_OR:   res = in1 | in2;
            OP_XOR:  res = in1 ^ in2;
            OP_NOT:  res = ~in1;
            OP_SHL: begin
                res   = shl_ext[WIDTH-1:0];
                carry = shl_ext[WIDTH];
            end
            OP_SHR: begin
                res   = shr_ext[WIDTH:1];
                carry = shr_ext[0];
            end
            OP_SRA: begin
                res   = sra_ext[WIDTH:1];
                carry = sra_ext[0];
            end
            OP_ROL: begin
                res   = {in1[WIDTH-2:0], in1[WIDTH-1]};
                carry = in1[WIDTH-1];
            end
            OP_ROR: begin
                res   = {in1[0], in1[WIDTH-1:1]};
                carry = in1[0];
            end
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            OP_PASS: res = in2;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out     <= '0;
            parity_flag <= 1'b0;
            zero_flag   <= 1'b0;
            sign_flag   <= 1'b0;
            carry_flag  <= 1'b0;
        end else begin
            alu_out     <= res;
            parity_flag <= ^res;
            zero_flag   <= (res == '0);
            sign_flag   <= res[WIDTH-1];
            carry_flag  <= carry;
        end
    end

endmodule

// File: tb/tb_alu_32bit.sv
// Directed-vector bench for alu_32bit: driver queues hand-computed expectations, a monitor pops and compares each cycle.
module tb_alu_32bit;

    logic        clk;
    logic        rst;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  opcode;
    logic [31:0] alu_out;
    logic        parity_flag;
    logic        zero_flag;
    logic        sign_flag;
    logic        carry_flag;

    typedef struct packed {
        logic [15:0] id;
        logic        rst;
        logic [31:0] res;
        logic        carry;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_id   = 0;

    alu_32bit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in1         (in1),
        .in2         (in2),
        .opcode      (opcode),
        .alu_out     (alu_out),
        .parity_flag (parity_flag),
        .zero_flag   (zero_flag),
        .sign_flag   (sign_flag),
        .carry_flag  (carry_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge so the DUT samples stable values.
    task automatic apply(input logic r, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic exp_c);
        exp_t e;
        @(negedge clk);
        rst    = r;
        opcode = op;
        in1    = a;
        in2    = b;
        e.id    = vec_id[15:0];
        e.rst   = r;
        e.res   = exp_res;
        e.carry = exp_c;
        q.push_back(e);
        vec_id++;
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t        e;
            logic [35:0] want;
            logic [35:0] got;
            e = q.pop_front();
            if (e.rst)
                want = 36'h0;
            else
                want = {e.res, ^e.res, (e.res == 32'h0), e.res[31], e.carry};
            got = {alu_out, parity_flag, zero_flag, sign_flag, carry_flag};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL vec%0d: got res=%h p=%b z=%b s=%b c=%b, want res=%h p=%b z=%b s=%b c=%b",
                         e.id, got[35:4], got[3], got[2], got[1], got[0],
                         want[35:4], want[3], want[2], want[1], want[0]);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        in1    = 32'd32;
        in2    = 32'd20;
        opcode = 4'd0;

        // Reset held for two edges, then release
        apply(1'b1, 4'd0, 32'd32, 32'd20, 32'd0, 1'b0);
        apply(1'b1, 4'd0, 32'd32, 32'd20, 32'd0, 1'b0);
        apply(1'b0, 4'd0, 32'd32, 32'd20, 32'd52, 1'b0);

        // Opcode sweep with in1=32, in2=20
        apply(1'b0, 4'd0,  32'd32, 32'd20, 32'd52,       1'b0);
        apply(1'b0, 4'd1,  32'd32, 32'd20, 32'd12,       1'b0);
        apply(1'b0, 4'd2,  32'd32, 32'd20, 32'd33,       1'b0);
        apply(1'b0, 4'd3,  32'd32, 32'd20, 32'd31,       1'b0);
        apply(1'b0, 4'd4,  32'd32, 32'd20, 32'd0,        1'b0);
        apply(1'b0, 4'd5,  32'd32, 32'd20, 32'd52,       1'b0);
        apply(1'b0, 4'd6,  32'd32, 32'd20, 32'd52,       1'b0);
        apply(1'b0, 4'd7,  32'd32, 32'd20, 32'hFFFFFFDF, 1'b0);
        apply(1'b0, 4'd8,  32'd32, 32'd20, 32'h02000000, 1'b0);
        apply(1'b0, 4'd9,  32'd32, 32'd20, 32'd0,        1'b0);
        apply(1'b0, 4'd10, 32'd32, 32'd20, 32'd0,        1'b0);
        apply(1'b0, 4'd11, 32'd32, 32'd20, 32'd64,       1'b0);
        apply(1'b0, 4'd12, 32'd32, 32'd20, 32'd16,       1'b0);
        apply(1'b0, 4'd13, 32'd32, 32'd20, 32'd0,        1'b0);
        apply(1'b0, 4'd14, 32'd32, 32'd20, 32'd0,        1'b0);
        apply(1'b0, 4'd15, 32'd32, 32'd20, 32'd20,       1'b0);

        // Borrow and signed/unsigned compare
        apply(1'b0, 4'd1,  32'd20,       32'd32, 32'hFFFFFFF4, 1'b1);
        apply(1'b0, 4'd13, 32'hFFFFFFFF, 32'd1,  32'd1,        1'b0);
        apply(1'b0, 4'd14, 32'hFFFFFFFF, 32'd1,  32'd0,        1'b0);

        // Carry wrap
        apply(1'b0, 4'd0, 32'hFFFFFFFF, 32'd1, 32'd0,        1'b1);
        apply(1'b0, 4'd2, 32'hFFFFFFFF, 32'd0, 32'd0,        1'b1);
        apply(1'b0, 4'd3, 32'd0,        32'd0, 32'hFFFFFFFF, 1'b1);

        // Shifts and rotates
        apply(1'b0, 4'd8,  32'h80000001, 32'd1,  32'h00000002, 1'b1);
        apply(1'b0, 4'd10, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0);
        apply(1'b0, 4'd10, 32'h80000000, 32'd4,  32'hF8000000, 1'b0);
        apply(1'b0, 4'd9,  32'h12345678, 32'h20, 32'h12345678, 1'b0);
        apply(1'b0, 4'd9,  32'h80000001, 32'd1,  32'h40000000, 1'b1);
        apply(1'b0, 4'd12, 32'd1,        32'd0,  32'h80000000, 1'b1);
        apply(1'b0, 4'd11, 32'h80000000, 32'd0,  32'h00000001, 1'b1);

        // Sweep with a one-edge reset in the middle
        apply(1'b0, 4'd3,  32'd32, 32'd20, 32'd31,       1'b0);
        apply(1'b0, 4'd4,  32'd32, 32'd20, 32'd0,        1'b0);
        apply(1'b1, 4'd5,  32'd32, 32'd20, 32'd0,        1'b0);
        apply(1'b0, 4'd6,  32'd32, 32'd20, 32'd52,       1'b0);
        apply(1'b0, 4'd7,  32'd32, 32'd20, 32'hFFFFFFDF, 1'b0);
        apply(1'b0, 4'd11, 32'd32, 32'd20, 32'd64,       1'b0);
        apply(1'b0, 4'd15, 32'd32, 32'd20, 32'd20,       1'b0);

        for (int i = 0; i < 20 && q.size() > 0; i++)
            @(posedge clk);
        #2;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_32bit.md
Name: alu_32bit

Overview:
- Registered 32-bit integer ALU. It takes two 32-bit operands and a 4-bit opcode and produces a 32-bit result plus parity, zero, sign and carry flags.
- Used as the datapath execute unit. Result and flags are captured on the clock edge.
- Single clock domain; synchronous active-high reset.

Parameters:
- WIDTH, 32, operand/result width. Fixed at 32; the opcode map assumes 32 and a 5-bit shift amount.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous reset, active-high
- in1  input  32  operand A
- in2  input  32  operand B; shift amount is in2[4:0]
- opcode  input  4  operation select
- alu_out  output  32  registered result
- parity_flag  output  1  registered; XOR-reduction of result (1 = odd number of ones)
- zero_flag  output  1  registered; 1 when result == 0
- sign_flag  output  1  registered; result[31]
- carry_flag  output  1  registered; carry/borrow/shifted-out bit, per opcode

Behaviour:
- Clocking and reset:
  - One clock, synchronous active-high reset.
  - On a rising clk edge with rst=1: alu_out=0 and all four flags=0. Reset dominates any opcode.
  - Otherwise, on every rising edge, result and flags are computed combinationally from the current in1/in2/opcode and registered.
- Latency and handshake:
  - Latency is 1 cycle. No enable and no handshake.
  - A new operation is accepted every cycle.
  - Outputs hold between edges.
- Opcode map (carry rule in brackets):
  - 0 ADD: in1+in2 [carry = bit 32 of the 33-bit sum]
  - 1 SUB: in1-in2 [carry = borrow, 1 when in1 < in2 unsigned]
  - 2 INC: in1+1 [carry = 1 when in1 = 0xFFFFFFFF]
  - 3 DEC: in1-1 [carry = 1 when in1 = 0]
  - 4 AND: in1&in2 [0]
  - 5 OR: in1|in2 [0]
  - 6 XOR: in1^in2 [0]
  - 7 NOT: ~in1 [0]
  - 8 SHL: in1 << in2[4:0] [last bit shifted out; 0 if amount 0]
  - 9 SHR logical: in1 >> in2[4:0] [last bit shifted out; 0 if amount 0]
  - 10 SRA arithmetic: in1 >>> in2[4:0], sign-filled [last bit shifted out; 0 if amount 0]
  - 11 ROL by 1 [carry = old in1[31]]
  - 12 ROR by 1 [carry = old in1[0]]
  - 13 SLT signed: 1 if in1 < in2 (two's complement), else 0 [0]
  - 14 SLTU unsigned: 1 if in1 < in2, else 0 [0]
  - 15 PASS B: in2 [0]
- Shift amount uses only in2[4:0]; in2[31:5] are ignored.
- Flags always derive from the 32-bit result of the same cycle. Exception: carry_flag follows the per-opcode rule above.
- Overflow is not reported; ADD/SUB results wrap modulo 2^32.
- Assertion of rst mid-stream clears the outputs at that edge. The first post-reset result appears one edge after rst deasserts.

Test Plan:
- Reset: hold rst=1 for 2 edges with in1=32, in2=20, opcode=0 -> alu_out=0 and all flags 0. Release rst -> next edge alu_out=52 (0x34), parity=1, zero=0, sign=0, carry=0.
- Opcode sweep 0..15 with in1=32, in2=20, one opcode per cycle. Each result appears one cycle after its opcode is applied:
  - ADD=52, SUB=12 (parity 0), INC=33, DEC=31
  - AND=0 (zero=1), OR=52, XOR=52, NOT=0xFFFFFFDF (sign=1)
  - SHL=0x02000000, SHR=0, SRA=0
  - ROL=64, ROR=16
  - SLT=0, SLTU=0, PASS=20
- Borrow/sign: SUB with in1=20, in2=32 -> 0xFFFFFFF4, sign=1, carry=1. SLT with in1=0xFFFFFFFF, in2=1 -> 1. SLTU with same operands -> 0.
- Carry wrap: ADD 0xFFFFFFFF+1 -> 0, zero=1, carry=1. INC 0xFFFFFFFF -> 0, carry=1. DEC 0 -> 0xFFFFFFFF, carry=1, parity=0.
- Shifts:
  - SHL in1=0x80000001, in2=1 -> 0x00000002, carry=1.
  - SRA in1=0x80000000, in2=31 -> 0xFFFFFFFF.
  - SHR in2=0x20 (amount 0) -> in1 unchanged, carry=0.
  - ROR in1=1 -> 0x80000000, carry=1.
- Mid-stream reset: assert rst for one edge during the opcode sweep -> outputs are 0 at that edge, and the sweep resumes with correct values afterwards.
